// File: rtl/adc_fft_pkg.sv
// Shared constants, sample type and helpers for the ADC-to-FFT frame scheduler
// and the FFT wrappers that consume its buffers.
package adc_fft_pkg;
  localparam int DEF_NUM_FFT         = 4;
  localparam int DEF_FRAME_LEN       = 2048;
  localparam int DEF_HOP             = 512;
  localparam int DEF_SAMPLE_W        = 12;
  localparam int DEF_SAMPLES_PER_SEC = 25000;
  localparam int DEF_FRAMES_PER_SEC  = 45;
  localparam int ADDR_W              = $clog2(DEF_FRAME_LEN);

  typedef logic [DEF_SAMPLE_W-1:0] sample_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adc_frame_scheduler_writer.sv
// One FFT input buffer: active flag, address counter, write strobe and the
// accept/drop decision for a frame start aimed at this buffer.
module fft_buffer_writer
  import adc_fft_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic          frame_start,
  input  logic          fft_busy,
  input  logic          window_end,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          frame_done,
  output logic          drop
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  logic          active_q, active_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          frame_done_q, frame_done_d;
  logic          accept_s, write_s;
  logic [AW-1:0] addr_s;

  // A start only lands on an idle buffer whose FFT has released it.
  always_comb begin
    accept_s     = frame_start & ~fft_busy & ~active_q;
    drop         = frame_start & ~accept_s;
    write_s      = accept_s | (sample_valid & active_q);
    addr_s       = accept_s ? '0 : cnt_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      active_d  = 1'b0;
      cnt_d     = '0;
      wr_addr_d = '0;
    end else if (write_s) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = addr_s;
      frame_done_d = (addr_s == LAST_ADDR);
      active_d     = (addr_s != LAST_ADDR) & ~window_end;
      cnt_d        = addr_s + AW'(1);
    end else begin
      active_d = active_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q     <= 1'b0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;
endmodule

// File: rtl/adc_frame_scheduler.sv
// Splits the ADC stream into overlapping frames, assigns them round-robin to
// NUM_FFT buffers, and budgets FRAMES_PER_SEC frame starts per one-second window.
module adc_frame_scheduler
  import adc_fft_pkg::*;
#(
  parameter int NUM_FFT         = DEF_NUM_FFT,
  parameter int FRAME_LEN       = DEF_FRAME_LEN,
  parameter int HOP             = DEF_HOP,
  parameter int SAMPLE_W        = DEF_SAMPLE_W,
  parameter int SAMPLES_PER_SEC = DEF_SAMPLES_PER_SEC,
  parameter int FRAMES_PER_SEC  = DEF_FRAMES_PER_SEC
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 adc_input_valid,
  input  logic [SAMPLE_W-1:0]                  adc_data,
  input  logic [NUM_FFT-1:0]                   fft_busy,
  output logic [NUM_FFT-1:0]                   wr_en,
  output logic [NUM_FFT*$clog2(FRAME_LEN)-1:0] wr_addr,
  output logic [SAMPLE_W-1:0]                  wr_data,
  output logic [NUM_FFT-1:0]                   frame_done,
  output logic                                 frame_dropped,
  output logic [15:0]                          drop_count,
  output logic                                 second_done
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int SW = cnt_w(SAMPLES_PER_SEC);
  localparam int HW = cnt_w(HOP);
  localparam int FW = cnt_w(FRAMES_PER_SEC + 1);
  localparam int BW = cnt_w(NUM_FFT);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES_PER_SEC - 1);
  localparam logic [HW-1:0] LAST_HOP    = HW'(HOP - 1);
  localparam logic [FW-1:0] FRAME_BUDGET = FW'(FRAMES_PER_SEC);
  localparam logic [BW-1:0] LAST_BUF    = BW'(NUM_FFT - 1);

  if (NUM_FFT * HOP < FRAME_LEN) begin : g_chk_buffers
    $fatal(1, "adc_frame_scheduler: NUM_FFT*HOP must be >= FRAME_LEN");
  end
  if ((FRAMES_PER_SEC - 1) * HOP + FRAME_LEN > SAMPLES_PER_SEC) begin : g_chk_budget
    $fatal(1, "adc_frame_scheduler: frame budget exceeds the one-second window");
  end
  if (!is_pow2(FRAME_LEN)) begin : g_chk_pow2
    $fatal(1, "adc_frame_scheduler: FRAME_LEN must be a power of two");
  end

  logic [SW-1:0]       sample_idx_q, sample_idx_d;
  logic [HW-1:0]       hop_cnt_q, hop_cnt_d;
  logic [FW-1:0]       frames_started_q, frames_started_d;
  logic [BW-1:0]       next_buf_q, next_buf_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                frame_dropped_q, frame_dropped_d;
  logic                second_done_q, second_done_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                sample_valid_s, window_end_s, frame_start_s;
  logic [NUM_FFT-1:0]  start_vec_s, drop_vec_s;

  // Frame timing advances on every accepted sample, dropped or not, so it never slips.
  always_comb begin
    sample_valid_s   = adc_input_valid & enable;
    window_end_s     = sample_valid_s & (sample_idx_q == LAST_SAMPLE);
    frame_start_s    = sample_valid_s & (hop_cnt_q == '0) & (frames_started_q < FRAME_BUDGET);
    for (int k = 0; k < NUM_FFT; k++) begin
      start_vec_s[k] = frame_start_s & (next_buf_q == BW'(k));
    end
    sample_idx_d     = sample_idx_q;
    hop_cnt_d        = hop_cnt_q;
    frames_started_d = frames_started_q;
    next_buf_d       = next_buf_q;
    drop_count_d     = drop_count_q;
    frame_dropped_d  = 1'b0;
    second_done_d    = 1'b0;
    wr_data_d        = wr_data_q;
    if (!enable) begin
      sample_idx_d     = '0;
      hop_cnt_d        = '0;
      frames_started_d = '0;
      next_buf_d       = '0;
      wr_data_d        = '0;
    end else if (sample_valid_s) begin
      wr_data_d       = adc_data;
      frame_dropped_d = |drop_vec_s;
      if ((|drop_vec_s) && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
      if (frame_start_s) begin
        next_buf_d = (next_buf_q == LAST_BUF) ? '0 : next_buf_q + BW'(1);
      end else begin
        next_buf_d = next_buf_q;
      end
      if (window_end_s) begin
        second_done_d    = 1'b1;
        sample_idx_d     = '0;
        hop_cnt_d        = '0;
        frames_started_d = '0;
      end else begin
        sample_idx_d     = sample_idx_q + SW'(1);
        hop_cnt_d        = (hop_cnt_q == LAST_HOP) ? '0 : hop_cnt_q + HW'(1);
        frames_started_d = frames_started_q + (frame_start_s ? FW'(1) : FW'(0));
      end
    end else begin
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_idx_q     <= '0;
      hop_cnt_q        <= '0;
      frames_started_q <= '0;
      next_buf_q       <= '0;
      drop_count_q     <= '0;
      frame_dropped_q  <= 1'b0;
      second_done_q    <= 1'b0;
      wr_data_q        <= '0;
    end else begin
      sample_idx_q     <= sample_idx_d;
      hop_cnt_q        <= hop_cnt_d;
      frames_started_q <= frames_started_d;
      next_buf_q       <= next_buf_d;
      drop_count_q     <= drop_count_d;
      frame_dropped_q  <= frame_dropped_d;
      second_done_q    <= second_done_d;
      wr_data_q        <= wr_data_d;
    end
  end

  for (genvar k = 0; k < NUM_FFT; k++) begin : g_buf
    fft_buffer_writer #(
      .FRAME_LEN (FRAME_LEN),
      .AW        (AW)
    ) u_writer (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sample_valid (sample_valid_s),
      .frame_start  (start_vec_s[k]),
      .fft_busy     (fft_busy[k]),
      .window_end   (window_end_s),
      .wr_en        (wr_en[k]),
      .wr_addr      (wr_addr[k*AW +: AW]),
      .frame_done   (frame_done[k]),
      .drop         (drop_vec_s[k])
    );
  end

  assign wr_data       = wr_data_q;
  assign frame_dropped = frame_dropped_q;
  assign drop_count    = drop_count_q;
  assign second_done   = second_done_q;
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler at default parameters.
module tb_adc_frame_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        adc_input_valid = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic [3:0]  fft_busy = 4'd0;
  logic [3:0]  wr_en;
  logic [43:0] wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  frame_done;
  logic        frame_dropped;
  logic [15:0] drop_count;
  logic        second_done;

  int tests_run = 0;
  int tests_failed = 0;

  adc_frame_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .adc_input_valid (adc_input_valid),
    .adc_data        (adc_data),
    .fft_busy        (fft_busy),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .frame_done      (frame_done),
    .frame_dropped   (frame_dropped),
    .drop_count      (drop_count),
    .second_done     (second_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] addr_of(input int k);
    return wr_addr[k*11 +: 11];
  endfunction

  function automatic logic [11:0] pat(input int i);
    return 12'((i * 3) + 1);
  endfunction

  task automatic drive(input logic v, input logic [11:0] d);
    @(negedge clk);
    adc_input_valid = v;
    adc_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    adc_input_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int fd_pulses, last_fd, late_wr, sd_count, sd_at, b2_writes;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_wr_en", {60'd0, wr_en}, 64'd0);
    check_eq("reset_addr", {20'd0, wr_addr}, 64'd0);
    check_eq("reset_drop_cnt", {48'd0, drop_count}, 64'd0);
    reset = 1'b1;

    // Full one-second window plus the first sample of the next one.
    fd_pulses = 0; last_fd = -1; late_wr = 0; sd_count = 0; sd_at = -1;
    for (int i = 0; i <= 25000; i++) begin
      drive(1'b1, pat(i));
      if (i < 25000) begin
        fd_pulses += $countones(frame_done);
        if (frame_done != 4'd0) last_fd = i;
        if (i >= 24576 && wr_en != 4'd0) late_wr++;
        if (second_done) begin sd_count++; sd_at = i; end
      end
      case (i)
        0: begin
          check_eq("s0_wr_en", {60'd0, wr_en}, 64'h1);
          check_eq("s0_addr0", {53'd0, addr_of(0)}, 64'd0);
          check_eq("s0_data", {52'd0, wr_data}, 64'd1);
        end
        512: begin
          check_eq("s512_wr_en", {60'd0, wr_en}, 64'h3);
          check_eq("s512_addr0", {53'd0, addr_of(0)}, 64'd512);
          check_eq("s512_addr1", {53'd0, addr_of(1)}, 64'd0);
          check_eq("s512_data", {52'd0, wr_data}, 64'd1537);
        end
        1536: begin
          check_eq("s1536_wr_en", {60'd0, wr_en}, 64'hF);
          check_eq("s1536_addr3", {53'd0, addr_of(3)}, 64'd0);
        end
        2047: begin
          check_eq("s2047_done", {60'd0, frame_done}, 64'h1);
          check_eq("s2047_addr0", {53'd0, addr_of(0)}, 64'd2047);
        end
        2048: begin
          check_eq("s2048_wr_en", {60'd0, wr_en}, 64'hF);
          check_eq("s2048_addr0", {53'd0, addr_of(0)}, 64'd0);
          check_eq("s2048_addr1", {53'd0, addr_of(1)}, 64'd1536);
          check_eq("s2048_done", {60'd0, frame_done}, 64'h0);
        end
        24575: check_eq("s24575_done", {60'd0, frame_done}, 64'h1);
        25000: begin
          check_eq("s25000_wr_en", {60'd0, wr_en}, 64'h2);
          check_eq("s25000_addr1", {53'd0, addr_of(1)}, 64'd0);
          check_eq("s25000_sd", {63'd0, second_done}, 64'd0);
        end
        default: ;
      endcase
    end
    check_eq("sec_fd_pulses", 64'(fd_pulses), 64'd45);
    check_eq("sec_last_fd", 64'(last_fd), 64'd24575);
    check_eq("sec_tail_writes", 64'(late_wr), 64'd0);
    check_eq("sec_sd_count", 64'(sd_count), 64'd1);
    check_eq("sec_sd_at", 64'(sd_at), 64'd24999);
    check_eq("sec_drop_cnt", {48'd0, drop_count}, 64'd0);

    // Asynchronous reset mid-frame.
    do_reset();
    for (int i = 0; i <= 700; i++) drive(1'b1, pat(i));
    check_eq("s700_addr0", {53'd0, addr_of(0)}, 64'd700);
    adc_input_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("arst_wr_en", {60'd0, wr_en}, 64'd0);
    check_eq("arst_addr", {20'd0, wr_addr}, 64'd0);
    check_eq("arst_data", {52'd0, wr_data}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, pat(0));
    check_eq("arst_first_wr_en", {60'd0, wr_en}, 64'h1);
    check_eq("arst_first_addr0", {53'd0, addr_of(0)}, 64'd0);

    // Buffer 2 busy at its frame start.
    do_reset();
    b2_writes = 0;
    for (int i = 0; i <= 1536; i++) begin
      fft_busy = (i == 1024) ? 4'b0100 : 4'b0000;
      drive(1'b1, pat(i));
      if (i >= 1024) b2_writes += int'(wr_en[2]);
      if (i == 1024) begin
        check_eq("busy_dropped", {63'd0, frame_dropped}, 64'd1);
        check_eq("busy_drop_cnt", {48'd0, drop_count}, 64'd1);
        check_eq("busy_wr_en", {60'd0, wr_en}, 64'h3);
      end
      if (i == 1025) check_eq("busy_drop_pulse", {63'd0, frame_dropped}, 64'd0);
      if (i == 1536) begin
        check_eq("busy_s1536_wr_en", {60'd0, wr_en}, 64'hB);
        check_eq("busy_s1536_addr3", {53'd0, addr_of(3)}, 64'd0);
      end
    end
    check_eq("busy_buf2_writes", 64'(b2_writes), 64'd0);

    // Enable dropped mid-run, then raised again.
    @(negedge clk);
    enable = 1'b0;
    drive(1'b1, pat(7));
    check_eq("en_lo_wr_en", {60'd0, wr_en}, 64'd0);
    check_eq("en_lo_addr", {20'd0, wr_addr}, 64'd0);
    check_eq("en_lo_done", {60'd0, frame_done}, 64'd0);
    check_eq("en_lo_drop_cnt", {48'd0, drop_count}, 64'd1);
    enable = 1'b1;
    for (int i = 0; i <= 512; i++) begin
      drive(1'b1, pat(i));
      if (i == 0) begin
        check_eq("en_hi_wr_en", {60'd0, wr_en}, 64'h1);
        check_eq("en_hi_addr0", {53'd0, addr_of(0)}, 64'd0);
        check_eq("en_hi_drop_cnt", {48'd0, drop_count}, 64'd1);
      end
      if (i == 512) check_eq("en_hi_s512_wr_en", {60'd0, wr_en}, 64'h3);
    end

    // Sparse strobes: one valid sample every 1000 cycles.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, pat(j + 40));
      check_eq("gap_wr_en", {60'd0, wr_en}, 64'h1);
      check_eq("gap_addr0", {53'd0, addr_of(0)}, 64'(j));
      check_eq("gap_data", {52'd0, wr_data}, {52'd0, pat(j + 40)});
      drive(1'b0, 12'd0);
      check_eq("gap_idle_wr_en", {60'd0, wr_en}, 64'd0);
      for (int c = 0; c < 998; c++) drive(1'b0, 12'd0);
      check_eq("gap_hold_addr0", {53'd0, addr_of(0)}, 64'(j));
      check_eq("gap_hold_data", {52'd0, wr_data}, {52'd0, pat(j + 40)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
